time_keeper: RTL and testbench
==============================

# time_keeper

Time-of-day counter that sits directly downstream of the mode generator in the digital clock chip. It derives a one-second tick from `clk` with an internal prescaler and keeps hours, minutes and seconds in 24-hour format. It applies the generator's one-cycle `increase` pulses to the field selected by `mode1`/`mode2`. It emits a day-rollover pulse for the date counter.

## Interface
- `CLKS_PER_SEC`, default 100: `clk` cycles per second; legal range ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode1`  in  2  major mode; encodings 2'b00 TIME, 2'b01 DATE, 2'b10 TIMER, 2'b11 ALARM.
- `mode2`  in  2  minor mode; in TIME the encodings are 2'b00 G, 2'b01 HOUR, 2'b10 MIN, 2'b11 SEC.
- `increase`  in  1  edit request pulse, sampled on the rising edge of `clk`.
- `hour`  out  5  hours, 0–23, binary.
- `min`  out  6  minutes, 0–59, binary.
- `sec`  out  6  seconds, 0–59, binary.
- `day_carry`  out  1  one-cycle pulse on rollover from 23:59:59 to 00:00:00.

## Operation
- **Prescaler**
  - `presc` counts 0..CLKS_PER_SEC-1 and wraps.
  - Internal `tick` is asserted in the cycle where `presc == CLKS_PER_SEC-1`.
- **Counting on `tick`**
  - `sec` increments; 59 wraps to 0 and carries to `min`.
  - `min` 59 wraps to 0 and carries to `hour`.
  - `hour` 23 wraps to 0 and asserts `day_carry`.
- **Edit is active** only when `increase==1` and `mode1==TIME` and `mode2!=G`.
  - `increase` in any other mode combination is ignored.
- **Edit actions**
  - HOUR: `hour` +1; 23 wraps to 0. No effect on other fields. No `day_carry`.
  - MIN: `min` +1; 59 wraps to 0. No carry into `hour`.
  - SEC: `sec` cleared to 0. `presc` cleared to 0 in the same edge, so a full second elapses before the next tick.
- **Tick and edit in the same cycle**
  - The tick advance is computed first.
  - The edit is then applied to the selected field of the advanced value.
  - `day_carry` follows the tick result only.
  - Exception, SEC edit: the result is `sec=0` and `presc=0`. Any carry the tick would have produced into `min`/`hour` is still applied.
- **Continuous increments:** each rising edge with an active edit counts once. `increase` held high N cycles gives N increments.
- **Unknown or X mode inputs:** treated as no edit.

## Timing
- **Reset values:**
  - `hour`=0, `min`=0, `sec`=0, `day_carry`=0, `presc`=0.
  - Reset is asynchronous on assertion and synchronous on release: the first count happens at the edge after release.
- **Latency:**
  - All outputs are registered.
  - A `tick` or `increase` sampled at edge k is visible on the outputs after edge k.
  - `day_carry` is high for exactly the one cycle following the rolling edge.
- **Tick spacing:** the first tick after reset occurs on the CLKS_PER_SEC-th rising edge after release; ticks then repeat every CLKS_PER_SEC cycles.
- **`increase` timing:** `increase` is launched on the falling edge upstream and is stable at the rising edge. No synchronizer is required.
- **Reset mid-operation:** reset aborts any pending edit. The time returns to 00:00:00 and no `day_carry` is emitted.

## Test plan
All scenarios use CLKS_PER_SEC=4.
1. Reset, then run 4 cycles → `sec`=1 after the 4th edge. After 240 cycles total → 00:01:00.
2. Preload 23:59:59 via edits, then one tick → 00:00:00 and `day_carry` high for exactly 1 cycle. Check that `day_carry` is low both before and after.
3. `mode1`=TIME, `mode2`=HOUR, 25 `increase` pulses from hour 0 → `hour`=1, with no `day_carry`. Then `mode2`=MIN, 61 pulses from 0 → `min`=1 and `hour` unchanged.
4. `mode1`=DATE (and separately TIME/G, TIMER, ALARM), `increase` pulses → time unchanged apart from normal ticking.
5. `sec`=37 with `presc`=2, then a SEC edit → `sec`=0 and the next tick arrives 4 cycles later. Same-cycle tick plus MIN edit at 00:59:59 → 01:00:00 becomes 01:01:00.
6. Assert `reset_n` mid-count at 12:34:56, asynchronously between edges → all outputs are 0 immediately and counting resumes correctly after release.

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper: 24-hour time-of-day counter with prescaled one-second tick, field edits and day-rollover pulse
//   clk, reset_n (async active-low) | mode1/mode2 select the edited field | increase: edit pulse
//   hour/min/sec: binary time of day | day_carry: one-cycle pulse on 23:59:59 -> 00:00:00
module time_keeper #(
  parameter int CLKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode1,
  input  logic [1:0] mode2,
  input  logic       increase,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       day_carry
);
  localparam int PW = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_SEC - 1);
  localparam logic [1:0] TIME = 2'b00;
  localparam logic [1:0] HOUR = 2'b01;
  localparam logic [1:0] MIN  = 2'b10;
  logic [PW-1:0] presc, presc_n;
  logic [4:0] hour_t, hour_n;
  logic [5:0] min_t, min_n, sec_n;
  logic tick, sec_c, min_c, day_n;
  always_comb begin
    tick    = presc == LAST;
    sec_c   = tick && sec == 6'd59;
    min_c   = sec_c && min == 6'd59;
    sec_n   = tick ? (sec_c ? 6'd0 : sec + 6'd1) : sec;
    min_t   = sec_c ? (min_c ? 6'd0 : min + 6'd1) : min;
    hour_t  = min_c ? (hour == 5'd23 ? 5'd0 : hour + 5'd1) : hour;
    day_n   = min_c && hour == 5'd23;
    presc_n = tick ? '0 : presc + PW'(1);
    min_n   = min_t;
    hour_n  = hour_t;
    // Edits land on the already-advanced value; an unknown mode never qualifies.
    if (increase && mode1 == TIME && mode2 != 2'b00) begin
      if (mode2 == HOUR)
        hour_n = hour_t == 5'd23 ? 5'd0 : hour_t + 5'd1;
      else if (mode2 == MIN)
        min_n = min_t == 6'd59 ? 6'd0 : min_t + 6'd1;
      else begin
        sec_n   = 6'd0;
        presc_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      hour      <= 5'd0;
      min       <= 6'd0;
      sec       <= 6'd0;
      day_carry <= 1'b0;
    end else begin
      presc     <= presc_n;
      hour      <= hour_n;
      min       <= min_n;
      sec       <= sec_n;
      day_carry <= day_n;
    end
  end
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: table-driven and directed checks of time_keeper with CLKS_PER_SEC=4
module tb_time_keeper;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] mode1 = 2'b00;
  logic [1:0] mode2 = 2'b00;
  logic increase = 1'b0;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic day_carry;
  int total = 0;
  int bad = 0;

  time_keeper #(.CLKS_PER_SEC(4)) dut (
    .clk(clk), .reset_n(reset_n), .mode1(mode1), .mode2(mode2), .increase(increase),
    .hour(hour), .min(min), .sec(sec), .day_carry(day_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m1;
    logic [1:0] m2;
    logic       inc;
    int         n;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s, input logic dc);
    total++;
    if ({hour, min, sec, day_carry} !== {h, m, s, dc}) begin
      bad++;
      $display("FAIL %s: got %0d:%0d:%0d dc=%0b, want %0d:%0d:%0d dc=%0b", name, hour, min, sec, day_carry, h, m, s, dc);
    end
  endtask

  // Call at a falling edge; returns at the falling edge after n rising edges.
  task automatic run(input logic [1:0] m1, input logic [1:0] m2, input logic inc, input int n);
    mode1 = m1;
    mode2 = m2;
    increase = inc;
    repeat (n) @(negedge clk);
    mode1 = 2'b00;
    mode2 = 2'b00;
    increase = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mode1 = 2'b00;
    mode2 = 2'b00;
    increase = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{2'b00, 2'b00, 1'b1, 4,   0, 0, 1};
    tbl[1]  = '{2'b00, 2'b01, 1'b1, 3,   3, 0, 0};
    tbl[2]  = '{2'b00, 2'b01, 1'b1, 25,  1, 0, 6};
    tbl[3]  = '{2'b00, 2'b10, 1'b1, 61,  0, 1, 15};
    tbl[4]  = '{2'b00, 2'b11, 1'b1, 10,  0, 0, 0};
    tbl[5]  = '{2'b01, 2'b01, 1'b1, 8,   0, 0, 2};
    tbl[6]  = '{2'b10, 2'b10, 1'b1, 8,   0, 0, 2};
    tbl[7]  = '{2'b11, 2'b11, 1'b1, 12,  0, 0, 3};
    tbl[8]  = '{2'b00, 2'b00, 1'b0, 240, 0, 1, 0};
    tbl[9]  = '{2'b01, 2'b11, 1'b1, 5,   0, 0, 1};
    tbl[10] = '{2'b00, 2'b10, 1'b1, 60,  0, 0, 15};
    tbl[11] = '{2'b00, 2'b01, 1'b1, 24,  0, 0, 6};
    for (int i = 0; i < 12; i++) begin
      do_reset();
      run(tbl[i].m1, tbl[i].m2, tbl[i].inc, tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].s, 1'b0);
    end

    // Day rollover from 23:59:59.
    do_reset();
    run(2'b00, 2'b01, 1'b1, 23);
    run(2'b00, 2'b10, 1'b1, 59);
    run(2'b00, 2'b11, 1'b1, 1);
    run(2'b00, 2'b00, 1'b0, 236);
    chk("preload", 23, 59, 59, 0);
    run(2'b00, 2'b00, 1'b0, 3);
    chk("pre_roll", 23, 59, 59, 0);
    run(2'b00, 2'b00, 1'b0, 1);
    chk("roll", 0, 0, 0, 1);
    run(2'b00, 2'b00, 1'b0, 1);
    chk("post_roll", 0, 0, 0, 0);

    // SEC edit at sec=37, presc=2 restarts a full second.
    do_reset();
    run(2'b00, 2'b00, 1'b0, 150);
    chk("sec37", 0, 0, 37, 0);
    run(2'b00, 2'b11, 1'b1, 1);
    chk("sec_clr", 0, 0, 0, 0);
    run(2'b00, 2'b00, 1'b0, 3);
    chk("sec_wait3", 0, 0, 0, 0);
    run(2'b00, 2'b00, 1'b0, 1);
    chk("sec_tick4", 0, 0, 1, 0);

    // Tick and MIN edit on the same edge at 00:59:59.
    do_reset();
    run(2'b00, 2'b10, 1'b1, 59);
    run(2'b00, 2'b11, 1'b1, 1);
    run(2'b00, 2'b00, 1'b0, 236);
    chk("pre_same", 0, 59, 59, 0);
    run(2'b00, 2'b00, 1'b0, 3);
    run(2'b00, 2'b10, 1'b1, 1);
    chk("tick_min", 1, 1, 0, 0);

    // Asynchronous reset mid-count at 12:34:56 with an edit pending.
    do_reset();
    run(2'b00, 2'b01, 1'b1, 12);
    run(2'b00, 2'b10, 1'b1, 34);
    run(2'b00, 2'b11, 1'b1, 1);
    run(2'b00, 2'b00, 1'b0, 224);
    chk("t123456", 12, 34, 56, 0);
    mode2 = 2'b01;
    increase = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    increase = 1'b0;
    mode2 = 2'b00;
    reset_n = 1'b1;
    run(2'b00, 2'b00, 1'b0, 3);
    chk("rst_wait3", 0, 0, 0, 0);
    run(2'b00, 2'b00, 1'b0, 1);
    chk("rst_tick4", 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
